// File: rtl/pixel_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_stream_pkg
//  Brief    : Raster timing defaults, FSM encoding and FIFO sizing.
//  Revision : 1.0
// ============================================================================
package pixel_stream_pkg;

    localparam int c_h_active_def = 640;
    localparam int c_h_total_def  = 800;
    localparam int c_v_active_def = 480;
    localparam int c_v_total_def  = 525;

    localparam int c_cnt_w      = 13;
    localparam int c_pixel_w    = 24;
    localparam int c_fifo_depth = 4;
    localparam int c_fifo_cnt_w = $clog2(c_fifo_depth + 1);

    typedef logic [1:0] state_t;
    localparam state_t c_st_idle   = 2'd0;
    localparam state_t c_st_active = 2'd1;
    localparam state_t c_st_hblank = 2'd2;
    localparam state_t c_st_vblank = 2'd3;

endpackage
`default_nettype wire

// File: rtl/pixel_stream_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_stream_tx_if
//  Brief    : Upstream valid/ready pixel stream into the transmitter.
//  Revision : 1.0
// ============================================================================
interface pixel_stream_tx_if;
    import pixel_stream_pkg::*;

    logic [c_pixel_w-1:0] in_pixel;
    logic                 in_valid;
    logic                 in_ready;

    modport master (output in_pixel, output in_valid, input  in_ready);
    modport slave  (input  in_pixel, input  in_valid, output in_ready);

endinterface
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_fifo
//  Brief    : Small synchronous FIFO with occupancy count, head always visible.
//  Revision : 1.0
// ============================================================================
module pixel_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  wire              clk,
    input  wire              rst_n,
    input  wire              wr_en,
    input  wire  [WIDTH-1:0] wr_data,
    input  wire              rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_wr;
    logic               w_rd;

    assign full    = (r_count == CNT_W'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];
    assign w_wr    = wr_en && !full;
    assign w_rd    = rd_en && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;
            if (w_wr && !w_rd)      r_count <= r_count + 1'b1;
            else if (!w_wr && w_rd) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/pixel_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_stream_tx
//  Brief    : Raster timing generator draining a pixel FIFO onto r/g/b.
//  Revision : 1.0
// ============================================================================
module pixel_stream_tx
    import pixel_stream_pkg::*;
#(
    parameter int H_ACTIVE = c_h_active_def,
    parameter int H_TOTAL  = c_h_total_def,
    parameter int V_ACTIVE = c_v_active_def,
    parameter int V_TOTAL  = c_v_total_def
) (
    input  wire                clk,
    input  wire                rst_n,
    input  wire                start,
    pixel_stream_tx_if.slave   px,
    output logic [7:0]         r,
    output logic [7:0]         g,
    output logic [7:0]         b,
    output logic [c_cnt_w-1:0] col,
    output logic [c_cnt_w-1:0] x_count,
    output logic [c_cnt_w-1:0] row,
    output logic               active,
    output logic               frame_start,
    output logic [7:0]         underflow_cnt
);

    localparam logic [c_cnt_w-1:0] c_h_act_last = c_cnt_w'(H_ACTIVE - 1);
    localparam logic [c_cnt_w-1:0] c_h_tot_last = c_cnt_w'(H_TOTAL - 1);
    localparam logic [c_cnt_w-1:0] c_v_act_last = c_cnt_w'(V_ACTIVE - 1);
    localparam logic [c_cnt_w-1:0] c_v_tot_last = c_cnt_w'(V_TOTAL - 1);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [c_cnt_w-1:0]      r_x_count, r_row, r_col;
    logic [c_cnt_w-1:0]      w_x_next, w_row_next, w_col_next;
    logic [c_pixel_w-1:0]    r_pixel;
    logic [7:0]              r_uf;
    logic                    r_ready_en;
    logic                    w_line_end, w_push, w_pop, w_starve, w_refill_ok;
    logic [c_pixel_w-1:0]    w_fifo_rd_data;
    logic [c_fifo_cnt_w-1:0] w_fifo_count;
    logic                    w_fifo_full, w_fifo_empty;

    pixel_fifo #(
        .DEPTH (c_fifo_depth),
        .WIDTH (c_pixel_w),
        .CNT_W (c_fifo_cnt_w)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_push),
        .wr_data (px.in_pixel),
        .rd_en   (w_pop),
        .rd_data (w_fifo_rd_data),
        .count   (w_fifo_count),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    // in_ready stays low until the first clock after reset release.
    assign px.in_ready = r_ready_en && !w_fifo_full;
    assign w_push      = px.in_valid && px.in_ready;
    assign w_line_end  = (r_x_count == c_h_tot_last);
    assign w_refill_ok = start && (w_fifo_count == c_fifo_cnt_w'(c_fifo_depth));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_st_idle;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:   if (w_refill_ok) w_next_state = c_st_active;
            c_st_active: if (r_x_count == c_h_act_last) w_next_state = c_st_hblank;
            c_st_hblank: if (w_line_end)
                             w_next_state = (r_row == c_v_act_last) ? c_st_vblank : c_st_active;
            c_st_vblank: if (w_line_end && (r_row == c_v_tot_last))
                             w_next_state = w_refill_ok ? c_st_active : c_st_idle;
            default:     w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        active      = (r_state == c_st_active);
        frame_start = active && (r_row == '0) && (r_x_count == '0);
    end

    // The pixel is popped on the edge that enters the active cycle, so the
    // registered r/g/b line up with x_count/col of that cycle.
    assign w_pop    = (w_next_state == c_st_active) && !w_fifo_empty;
    assign w_starve = (w_next_state == c_st_active) && w_fifo_empty;

    always_comb begin
        w_x_next   = '0;
        w_row_next = '0;
        if ((r_state != c_st_idle) && (w_next_state != c_st_idle)) begin
            w_x_next   = w_line_end ? '0 : r_x_count + 1'b1;
            w_row_next = r_row;
            if (w_line_end) w_row_next = (r_row == c_v_tot_last) ? '0 : r_row + 1'b1;
        end
        if (w_next_state == c_st_active)    w_col_next = w_x_next;
        else if (w_next_state == c_st_idle) w_col_next = '0;
        else                                w_col_next = c_h_act_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_count  <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_pixel    <= '0;
            r_uf       <= '0;
            r_ready_en <= 1'b0;
        end else begin
            r_x_count  <= w_x_next;
            r_row      <= w_row_next;
            r_col      <= w_col_next;
            r_pixel    <= w_pop ? w_fifo_rd_data : '0;
            r_ready_en <= 1'b1;
            if (w_starve && (r_uf != 8'hFF)) r_uf <= r_uf + 8'd1;
        end
    end

    assign r             = r_pixel[23:16];
    assign g             = r_pixel[15:8];
    assign b             = r_pixel[7:0];
    assign col           = r_col;
    assign x_count       = r_x_count;
    assign row           = r_row;
    assign underflow_cnt = r_uf;

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_stream_tx
//  Brief    : Self-checking bench for pixel_stream_tx on a reduced raster.
//  Revision : 1.0
// ============================================================================
module tb_pixel_stream_tx;

    localparam int HA = 16;
    localparam int HT = 20;
    localparam int VA = 6;
    localparam int VT = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  r, g, b;
    logic [12:0] col, x_count, row;
    logic        active, frame_start;
    logic [7:0]  underflow_cnt;

    pixel_stream_tx_if px_if ();

    pixel_stream_tx #(
        .H_ACTIVE (HA),
        .H_TOTAL  (HT),
        .V_ACTIVE (VA),
        .V_TOTAL  (VT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .px            (px_if),
        .r             (r),
        .g             (g),
        .b             (b),
        .col           (col),
        .x_count       (x_count),
        .row           (row),
        .active        (active),
        .frame_start   (frame_start),
        .underflow_cnt (underflow_cnt)
    );

    always #5 clk = ~clk;

    // Reference: a running flag plus a linear position within the frame,
    // and a queue standing in for the FIFO.
    logic [23:0] m_q[$];
    bit          m_run;
    int          m_t;
    int          m_uf;
    bit          m_ren;
    logic [23:0] m_rgb;

    int checks   = 0;
    int failures = 0;
    int data_ctr = 0;
    bit inc_mode = 1'b1;

    typedef struct {
        int t; int x; int y; int c; bit a; bit fs; int pix;
    } vec_t;
    vec_t tab[12];

    function automatic bit m_ready();
        return m_ren && (m_q.size() < 4);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_run = 1'b0; m_t = 0; m_uf = 0; m_ren = 1'b0; m_rgb = '0;
    endtask

    task automatic model_update();
        bit push, nrun, nact;
        int nt;
        push = px_if.in_valid && m_ready();
        if (!m_run) begin
            nt   = 0;
            nrun = start && (m_q.size() == 4);
        end else begin
            nt   = m_t + 1;
            nrun = 1'b1;
            if (nt == HT * VT) begin
                nt   = 0;
                nrun = start && (m_q.size() == 4);
            end
        end
        nact = nrun && ((nt % HT) < HA) && ((nt / HT) < VA);
        if (nact && (m_q.size() > 0)) begin
            m_rgb = m_q.pop_front();
        end else begin
            m_rgb = '0;
            if (nact && (m_uf < 255)) m_uf++;
        end
        if (push) m_q.push_back(px_if.in_pixel);
        m_run = nrun; m_t = nt; m_ren = 1'b1;
    endtask

    function automatic logic [79:0] dut_vec();
        return 80'({r, g, b, col, x_count, row, active, frame_start, underflow_cnt, px_if.in_ready});
    endfunction

    function automatic logic [79:0] mdl_vec();
        int x, y, c;
        bit a;
        x = m_t % HT;
        y = m_t / HT;
        a = m_run && (x < HA) && (y < VA);
        c = !m_run ? 0 : (a ? x : HA - 1);
        return 80'({m_rgb, 13'(c), 13'(x), 13'(y), a, a && (m_t == 0), 8'(m_uf), m_ready()});
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        bit acc;
        acc = px_if.in_valid && m_ready();
        @(posedge clk);
        if (rst_n) model_update();
        else       model_reset();
        @(negedge clk);
        if (acc) data_ctr++;
        if (inc_mode) px_if.in_pixel = 24'(data_ctr);
        check("cycle", dut_vec(), mdl_vec());
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int cnt;
        tab[0]  = '{0,   0,  0, 0,  1'b1, 1'b1, 0};
        tab[1]  = '{1,   1,  0, 1,  1'b1, 1'b0, 1};
        tab[2]  = '{15,  15, 0, 15, 1'b1, 1'b0, 15};
        tab[3]  = '{16,  16, 0, 15, 1'b0, 1'b0, 0};
        tab[4]  = '{19,  19, 0, 15, 1'b0, 1'b0, 0};
        tab[5]  = '{20,  0,  1, 0,  1'b1, 1'b0, 16};
        tab[6]  = '{100, 0,  5, 0,  1'b1, 1'b0, 80};
        tab[7]  = '{115, 15, 5, 15, 1'b1, 1'b0, 95};
        tab[8]  = '{120, 0,  6, 15, 1'b0, 1'b0, 0};
        tab[9]  = '{159, 19, 7, 15, 1'b0, 1'b0, 0};
        tab[10] = '{160, 0,  0, 0,  1'b1, 1'b1, 96};
        tab[11] = '{161, 1,  0, 1,  1'b1, 1'b0, 97};

        px_if.in_valid = 1'b0;
        px_if.in_pixel = '0;
        model_reset();
        @(negedge clk);
        check("reset_outputs", dut_vec(), 80'd0);

        rst_n = 1'b1;
        start = 1'b1;
        px_if.in_valid = 1'b1;
        px_if.in_pixel = 24'(data_ctr);
        #1 check("ready_before_first_clk", 80'(px_if.in_ready), 80'd0);
        step();
        check("ready_after_first_clk", 80'(px_if.in_ready), 80'd1);
        n = 1;
        while (!frame_start && n < 50) begin step(); n++; end
        check("first_frame_latency", 80'(n), 80'd6);

        // Two full frames of incrementing data, spot-checked at table points.
        for (int tt = 0; tt < 162; tt++) begin
            foreach (tab[i]) begin
                if (tab[i].t == tt)
                    check($sformatf("tab_t%0d", tt),
                          80'({r, g, b, col, x_count, row, active, frame_start}),
                          80'({24'(tab[i].pix), 13'(tab[i].c), 13'(tab[i].x), 13'(tab[i].y),
                               tab[i].a, tab[i].fs}));
            end
            step();
        end

        // Dropping start mid-frame finishes the frame, then idles.
        start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 170; k++) begin
            step();
            if (active) cnt++;
        end
        check("stop_active_count", 80'(cnt), 80'd93);
        check("idle_hold", 80'({x_count, row, active}), 80'd0);
        step(); step();
        check("idle_hold_later", 80'({x_count, row, active, frame_start}), 80'd0);

        // Restart, then async reset in the middle of row 2.
        start = 1'b1;
        n = 0;
        do begin step(); n++; end while (!frame_start && n < 20);
        check("restart_from_idle", 80'(frame_start), 80'd1);
        n = 0;
        while (!(row == 13'd2 && col == 13'd5 && active) && n < 200) begin step(); n++; end
        check("reach_row2_col5", 80'({row, col}), 80'({13'd2, 13'd5}));
        #2 rst_n = 1'b0;
        model_reset();
        #1 check("async_reset_outputs", dut_vec(), 80'd0);
        @(negedge clk);
        check("reset_held", dut_vec(), 80'd0);
        rst_n = 1'b1;
        n = 0;
        do begin step(); n++; end while (!frame_start && n < 50);
        check("post_reset_latency", 80'(n), 80'd6);

        // Starve the FIFO at the start of the frame.
        px_if.in_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k >= 4) check($sformatf("starve_rgb_t%0d", k), 80'({active, r, g, b}), 80'({1'b1, 24'd0}));
        end
        px_if.in_valid = 1'b1;
        step();
        check("starve_rgb_t6", 80'({active, r, g, b}), 80'({1'b1, 24'd0}));
        step();
        check("underflow_3", 80'(underflow_cnt), 80'd3);

        // Feed only during blanking so every active row starves heavily.
        for (int k = 0; k < 1000; k++) begin
            px_if.in_valid = !active;
            step();
        end
        check("underflow_saturated", 80'(underflow_cnt), 80'd255);

        // Randomised traffic against the reference.
        pulse_reset();
        inc_mode = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (k % 150 == 0) start = ($urandom_range(0, 3) != 0);
            px_if.in_valid = ($urandom_range(0, 3) != 0);
            px_if.in_pixel = 24'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_stream_tx.md
PIXEL_STREAM_TX -- requirements
Module: pixel_stream_tx

Interface
REQ-001 Parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 Parameter H_TOTAL, default 800: clocks per line, active plus blanking.
REQ-003 Parameter V_ACTIVE, default 480: active lines per frame.
REQ-004 Parameter V_TOTAL, default 525: lines per frame, active plus blanking.
REQ-005 Port clk, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port start, input, 1: level enable; raster runs while high.
REQ-008 Port in_pixel, input, 24: upstream pixel {r,g,b}.
REQ-009 Port in_valid, input, 1: upstream pixel valid.
REQ-010 Port in_ready, output, 1: block accepts in_pixel this cycle.
REQ-011 Ports r, g, b, output, 8 each: pixel to the filter chain.
REQ-012 Port col, output, 13: active column index 0..H_ACTIVE-1; holds H_ACTIVE-1 during blanking.
REQ-013 Port x_count, output, 13: horizontal clock count 0..H_TOTAL-1.
REQ-014 Port row, output, 13: line count 0..V_TOTAL-1.
REQ-015 Port active, output, 1: r/g/b/col are a valid active pixel.
REQ-016 Port frame_start, output, 1: one-cycle pulse with pixel (0,0).
REQ-017 Port underflow_cnt, output, 8: saturating count of starved active pixels.

Function
REQ-018 The block SHALL contain a 4-entry, 24-bit FIFO; in_ready SHALL equal FIFO not full, and a write SHALL occur when in_valid and in_ready are both high.
REQ-019 The FSM SHALL have states IDLE, ACTIVE, HBLANK and VBLANK.
REQ-020 IDLE->ACTIVE SHALL occur when start=1 and the FIFO holds 4 entries; x_count, row and col SHALL be 0 on the first ACTIVE cycle.
REQ-021 In ACTIVE the block SHALL pop one FIFO entry per clock onto r/g/b, with active=1; the output pixel SHALL be registered, giving 1-cycle latency from pop to output.
REQ-022 In ACTIVE with an empty FIFO, r/g/b SHALL be 0, active SHALL stay 1, col SHALL still advance, and underflow_cnt SHALL increment, saturating at 255.
REQ-023 x_count SHALL increment every non-IDLE cycle and wrap H_TOTAL-1 -> 0, at which point row SHALL increment; row SHALL wrap V_TOTAL-1 -> 0.
REQ-024 ACTIVE->HBLANK SHALL occur after col=H_ACTIVE-1.
REQ-025 HBLANK->ACTIVE SHALL occur at the x_count wrap while row+1 < V_ACTIVE.
REQ-026 HBLANK->VBLANK SHALL occur at the x_count wrap when row+1 = V_ACTIVE.
REQ-027 VBLANK SHALL return to ACTIVE at the frame wrap if start=1 and the FIFO holds 4 entries; otherwise it SHALL go to IDLE.
REQ-028 frame_start SHALL be high only on the cycle with row=0, x_count=0 and state ACTIVE.
REQ-029 start falling mid-frame SHALL NOT abort; the frame SHALL complete, and the FSM SHALL go to IDLE at its end.
REQ-030 A FIFO push and pop in the same cycle SHALL leave the occupancy unchanged; a push to a full FIFO SHALL NOT occur, because in_ready is low.

Reset
REQ-031 On rst_n=0, the FSM SHALL go to IDLE, the FIFO SHALL empty, and r/g/b, col, x_count, row, active, frame_start and underflow_cnt SHALL all be 0.
REQ-032 While in reset, in_ready SHALL be 0; after release it SHALL be 1 on the first clock.
REQ-033 Reset asserted mid-frame SHALL take effect immediately (asynchronously); after release, the block SHALL re-enter through IDLE.

Structure
REQ-034 Package pixel_stream_pkg SHALL hold the default timing constants, the FSM state encoding and the FIFO depth constant.
REQ-035 The FIFO SHALL be the sub-module pixel_fifo (depth 4, width 24, count output); the counters and FSM SHALL stay in pixel_stream_tx.

Verification
REQ-036 Reset, start=1, continuous in_valid with an incrementing pattern: frame_start SHALL pulse at (0,0); row 0 SHALL carry pixels 0..639 with col 0..639; active SHALL be low at x_count 640..799.
REQ-037 in_valid dropped for 3 active cycles while the FIFO drains: r/g/b SHALL be 000000 on starved cycles, and underflow_cnt SHALL be 3.
REQ-038 Row 479 end: the FSM SHALL reach VBLANK with active=0 for rows 480..524, then frame_start SHALL pulse again.
REQ-039 start deasserted at row 100: rows 101..479 SHALL still be output; after row 524 the FSM SHALL be IDLE with x_count held at 0.
REQ-040 rst_n pulsed low at row 200, col 300: all outputs SHALL be 0 within the same cycle, and after release the next frame_start SHALL occur only once the FIFO is full.
REQ-041 More than 255 starved pixels: underflow_cnt SHALL hold at 255.
